byte_stream_bridge: RTL and testbench
=====================================

// Module: byte_stream_bridge
// PURPOSE
//  Parametrised CPU<->link word bridge; successor to the fixed 8-bit PIO byte handshake in the Nios system.
//  Buffers CPU-written words in a TX FIFO and drains them to the link with valid/ready.
//  Captures link words on an asynchronous strobe into an RX FIFO for CPU reads.
//  Adds sticky overflow and occupancy counters; the old PIO scheme had neither.
// PARAMETERS
//  DATA_W       8  link/CPU word width, bits (1..32)
//  DEPTH       16  entries per FIFO; power of 2, >= 2
//  SYNC_STAGES  2  synchroniser flops on link_in_strobe (>= 2)
// PORTS
//  clk_clk          in   1          single system clock
//  reset_reset      in   1          synchronous, active-high reset
//  cpu_wr_data      in   DATA_W     word to transmit
//  cpu_wr_en        in   1          push cpu_wr_data into TX FIFO
//  tx_full          out  1          TX FIFO full
//  tx_count         out  CW         TX occupancy; CW = $clog2(DEPTH)+1
//  link_out_data    out  DATA_W     TX FIFO head
//  link_out_valid   out  1          head valid (= !tx_empty)
//  link_out_ready   in   1          downstream accepts (ex readytodownload)
//  link_in_data     in   DATA_W     incoming word, stable around strobe
//  link_in_strobe   in   1          async capture strobe (ex instrobe)
//  cpu_rd_data      out  DATA_W     RX FIFO head (first-word fall-through)
//  cpu_rd_en        in   1          pop RX FIFO
//  rx_empty         out  1          RX FIFO empty
//  rx_count         out  CW         RX occupancy
//  rx_overflow      out  1          sticky: word dropped because RX full
//  clr_overflow     in   1          clears rx_overflow
//  csum_clr         in   1          clears checksums (used only with STREAM_CHECKSUM_EN)
//  tx_csum, rx_csum out  DATA_W     running checksums
// BEHAVIOUR
//  Reset: all pointers/counts 0; tx_full=0, link_out_valid=0, rx_empty=1, rx_overflow=0.
//   Sync chain and edge-detect history cleared; link_out_data, cpu_rd_data, checksums = 0.
//  Reset mid-transfer discards all FIFO contents. No word is emitted in the reset cycle.
//  TX push: cpu_wr_en && !tx_full -> store. Push while full is ignored; no flag is set.
//   Full is evaluated on pre-edge state, so a push+pop on a full FIFO rejects the push.
//  TX pop: link_out_valid && link_out_ready at the edge -> advance head.
//   link_out_data holds stable while valid && !ready.
//  Latency: a push into an empty TX FIFO shows link_out_valid=1 on the next cycle.
//   Push+pop in the same cycle with count>0 leaves the count unchanged.
//  RX capture: link_in_strobe passes through SYNC_STAGES flops.
//   On a detected rising edge, link_in_data is registered and pushed 1 cycle later.
//   Total strobe->rx_empty=0 latency is SYNC_STAGES+2 cycles.
//   link_in_data must be stable from the strobe rise until that latency elapses.
//   Minimum strobe high/low time is 2 cycles.
//  RX push when full: word dropped, contents unchanged, rx_overflow<=1.
//   If a pop and a push coincide at full, the pop frees space first and the push is accepted.
//  cpu_rd_en when empty: ignored, pointers unchanged.
//   cpu_rd_data always reflects the current head; it is undefined-but-stable while empty.
//  rx_overflow: held until clr_overflow. A clear and a new overflow in the same cycle -> stays 1.
//  Pointers are log2(DEPTH) bits and wrap naturally; counts saturate at DEPTH by construction.
// CONFIGURATION
//  `define STREAM_CHECKSUM_EN:
//   tx_csum += each popped TX word; rx_csum += each accepted RX word.
//   Both sums are mod 2^DATA_W and update on the transfer edge.
//   csum_clr or reset zeroes both; a transfer in the same cycle as csum_clr yields csum = that word.
//  Without the macro: tx_csum/rx_csum tied to 0, csum_clr ignored, no adder logic generated.
// TESTING
//  Push 0x11,0x22,0x33 with ready=0 -> tx_count=3, link_out_data=0x11 held; ready=1 -> 0x11,0x22,0x33 on 3 consecutive edges.
//  Push 16 words (DEPTH=16), then a 17th -> tx_full=1, tx_count=16, 17th word never appears on the link.
//  Strobe 0xA5 -> rx_empty falls exactly SYNC_STAGES+2 cycles after the rise, cpu_rd_data=0xA5; cpu_rd_en -> rx_empty=1.
//  Fill RX with 16 strobes, send 17th (0xEE) -> rx_overflow=1; 0xEE is absent on readout; clr_overflow -> 0.
//  Assert reset while tx_count=5 and link busy -> next cycle tx_count=0, link_out_valid=0, rx_empty=1.
//  With STREAM_CHECKSUM_EN: transfer 0xF0,0x20 -> tx_csum=0x10 (wrapped); csum_clr -> 0.

Source files
------------

// File: rtl/byte_stream_bridge.sv
// CPU<->link word bridge: TX FIFO drained by valid/ready, RX FIFO filled from a synchronised strobe.
// Optional running checksums are built only when STREAM_CHECKSUM_EN is defined.
module byte_stream_bridge #(
  parameter  int DATA_W      = 8,
  parameter  int DEPTH       = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_wr_en,
  output logic              tx_full,
  output logic [CW-1:0]     tx_count,
  output logic [DATA_W-1:0] link_out_data,
  output logic              link_out_valid,
  input  logic              link_out_ready,
  input  logic [DATA_W-1:0] link_in_data,
  input  logic              link_in_strobe,
  output logic [DATA_W-1:0] cpu_rd_data,
  input  logic              cpu_rd_en,
  output logic              rx_empty,
  output logic [CW-1:0]     rx_count,
  output logic              rx_overflow,
  input  logic              clr_overflow,
  input  logic              csum_clr,
  output logic [DATA_W-1:0] tx_csum,
  output logic [DATA_W-1:0] rx_csum
);

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0]     tx_wr_ptr_q, tx_wr_ptr_d;
  logic [AW-1:0]     tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]     tx_count_q, tx_count_d;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CW'(DEPTH));
  // Valid is masked during reset so nothing is handed off in the reset cycle.
  assign link_out_valid = !tx_empty && !reset_reset;
  assign link_out_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr_q];
  assign tx_count       = tx_count_q;

  assign tx_push = cpu_wr_en && !tx_full;
  assign tx_pop  = link_out_valid && link_out_ready;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= cpu_wr_data;
  end

  // ---------------- RX strobe synchroniser and capture ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   strobe_prev_q;
  logic                   strobe_rise;
  logic [DATA_W-1:0]      cap_data_q;
  logic                   cap_pend_q;

  assign sync_d[0] = link_in_strobe;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end

  assign strobe_rise = sync_q[SYNC_STAGES-1] && !strobe_prev_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
      cap_data_q    <= '0;
      cap_pend_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
      cap_pend_q    <= strobe_rise;
      if (strobe_rise) cap_data_q <= link_in_data;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     rx_wr_ptr_q, rx_wr_ptr_d;
  logic [AW-1:0]     rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]     rx_count_q, rx_count_d;
  logic              rx_overflow_q, rx_overflow_d;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_drop;

  assign rx_empty    = (rx_count_q == '0);
  assign rx_full     = (rx_count_q == CW'(DEPTH));
  assign cpu_rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
  assign rx_count    = rx_count_q;
  assign rx_overflow = rx_overflow_q;

  // A simultaneous pop frees the slot, so a capture at full is still accepted.
  assign rx_pop  = cpu_rd_en && !rx_empty;
  assign rx_push = cap_pend_q && (!rx_full || rx_pop);
  assign rx_drop = cap_pend_q && rx_full && !rx_pop;

  always_comb begin
    rx_wr_ptr_d   = rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_rd_ptr_q;
    rx_count_d    = rx_count_q;
    rx_overflow_d = rx_overflow_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
    if (rx_drop)           rx_overflow_d = 1'b1;
    else if (clr_overflow) rx_overflow_d = 1'b0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= cap_data_q;
  end

  // ---------------- Optional checksums ----------------
`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] tx_csum_q, tx_csum_d;
  logic [DATA_W-1:0] rx_csum_q, rx_csum_d;

  always_comb begin
    tx_csum_d = csum_clr ? '0 : tx_csum_q;
    rx_csum_d = csum_clr ? '0 : rx_csum_q;
    if (tx_pop)  tx_csum_d = tx_csum_d + link_out_data;
    if (rx_push) rx_csum_d = rx_csum_d + cap_data_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_csum_q <= '0;
      rx_csum_q <= '0;
    end else begin
      tx_csum_q <= tx_csum_d;
      rx_csum_q <= rx_csum_d;
    end
  end

  assign tx_csum = tx_csum_q;
  assign rx_csum = rx_csum_q;
`else
  logic unused_csum_clr;
  assign unused_csum_clr = csum_clr;
  assign tx_csum = '0;
  assign rx_csum = '0;
`endif

endmodule

// File: tb/tb_byte_stream_bridge.sv
// Self-checking bench for byte_stream_bridge: vector table for TX handshake, scoreboards for TX/RX words.
module tb_byte_stream_bridge;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int SS = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_reset;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_en;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic [DW-1:0] link_out_data;
  logic          link_out_valid;
  logic          link_out_ready;
  logic [DW-1:0] link_in_data;
  logic          link_in_strobe;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_en;
  logic          rx_empty;
  logic [CW-1:0] rx_count;
  logic          rx_overflow;
  logic          clr_overflow;
  logic          csum_clr;
  logic [DW-1:0] tx_csum;
  logic [DW-1:0] rx_csum;

  byte_stream_bridge #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_en(cpu_wr_en),
    .tx_full(tx_full), .tx_count(tx_count),
    .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
    .link_in_data(link_in_data), .link_in_strobe(link_in_strobe),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_en(cpu_rd_en),
    .rx_empty(rx_empty), .rx_count(rx_count), .rx_overflow(rx_overflow),
    .clr_overflow(clr_overflow), .csum_clr(csum_clr),
    .tx_csum(tx_csum), .rx_csum(rx_csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];

  typedef struct {
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          ready;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard entry only when the pre-edge FIFO is not full.
  task automatic push_tx(input logic [DW-1:0] d);
    cpu_wr_en = 1'b1;
    cpu_wr_data = d;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
    tick();
    cpu_wr_en = 1'b0;
  endtask

  task automatic send_rx(input logic [DW-1:0] d, input bit expect_accept);
    link_in_data = d;
    link_in_strobe = 1'b1;
    if (expect_accept) rx_q.push_back(d);
    repeat (3) tick();
    link_in_strobe = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    tick();
    tick();
    reset_reset = 1'b0;
  endtask

  // Transfers are decided by state sampled half a cycle before the edge.
  always @(negedge clk) begin
    if (!reset_reset && link_out_valid && link_out_ready) begin
      $display("tx word %02h", link_out_data);
      if (tx_q.size() == 0) check("tx_unexpected_word", {24'h0, link_out_data}, 32'hFFFF_FFFF);
      else check("tx_word", {24'h0, link_out_data}, {24'h0, tx_q.pop_front()});
    end
    if (!reset_reset && cpu_rd_en && !rx_empty) begin
      $display("rx word %02h", cpu_rd_data);
      if (rx_q.size() == 0) check("rx_unexpected_word", {24'h0, cpu_rd_data}, 32'hFFFF_FFFF);
      else check("rx_word", {24'h0, cpu_rd_data}, {24'h0, rx_q.pop_front()});
    end
  end

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 8'h11};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 8'h11};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 5'd3, 1'b1, 8'h11};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h22};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h33};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 8'h44, 1'b1, 5'd1, 1'b1, 8'h44};
    vecs[8] = '{1'b1, 8'h55, 1'b1, 5'd1, 1'b1, 8'h55};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};

    reset_reset = 1'b1;
    cpu_wr_data = '0; cpu_wr_en = 1'b0; link_out_ready = 1'b0;
    link_in_data = '0; link_in_strobe = 1'b0; cpu_rd_en = 1'b0;
    clr_overflow = 1'b0; csum_clr = 1'b0;
    do_reset();

    check("reset_tx_full", {31'h0, tx_full}, 32'h0);
    check("reset_tx_count", {27'h0, tx_count}, 32'h0);
    check("reset_valid", {31'h0, link_out_valid}, 32'h0);
    check("reset_link_data", {24'h0, link_out_data}, 32'h0);
    check("reset_rx_empty", {31'h0, rx_empty}, 32'h1);
    check("reset_rx_overflow", {31'h0, rx_overflow}, 32'h0);
    check("reset_rd_data", {24'h0, cpu_rd_data}, 32'h0);
    check("reset_csum", {16'h0, tx_csum, rx_csum}, 32'h0);

    // Table-driven TX handshake: hold with ready low, drain, push-into-empty, push+pop.
    for (int i = 0; i < 10; i++) begin
      link_out_ready = vecs[i].ready;
      if (vecs[i].wr_en) push_tx(vecs[i].wr_data);
      else tick();
      check($sformatf("vec%0d_count", i), {27'h0, tx_count}, {27'h0, vecs[i].exp_count});
      check($sformatf("vec%0d_valid", i), {31'h0, link_out_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), {24'h0, link_out_data}, {24'h0, vecs[i].exp_data});
    end
    check("tx_sb_drained_1", tx_q.size(), 0);

    // TX full: 16 words, a 17th rejected, then push+pop at full rejects the push.
    link_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_tx(8'h80 + 8'(i));
    check("tx_full_set", {31'h0, tx_full}, 32'h1);
    check("tx_count_16", {27'h0, tx_count}, 32'd16);
    push_tx(8'hEE);
    check("tx_count_after_17th", {27'h0, tx_count}, 32'd16);
    link_out_ready = 1'b1;
    push_tx(8'hEF);
    check("tx_pushpop_full", {27'h0, tx_count}, 32'd15);
    for (int k = 0; k < 40 && link_out_valid; k++) tick();
    check("tx_drain_done", {31'h0, link_out_valid}, 32'h0);
    check("tx_sb_drained_2", tx_q.size(), 0);
    link_out_ready = 1'b0;

    // RX latency: rx_empty falls exactly SYNC_STAGES+2 edges after the strobe rise.
    link_in_data = 8'hA5;
    link_in_strobe = 1'b1;
    rx_q.push_back(8'hA5);
    for (int k = 1; k <= SS + 2; k++) begin
      tick();
      if (k == SS + 1) check("rx_empty_before_latency", {31'h0, rx_empty}, 32'h1);
      if (k == SS + 2) check("rx_empty_at_latency", {31'h0, rx_empty}, 32'h0);
    end
    check("rx_head_a5", {24'h0, cpu_rd_data}, 32'hA5);
    repeat (2) tick();
    link_in_strobe = 1'b0;
    repeat (3) tick();
    cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    check("rx_empty_after_read", {31'h0, rx_empty}, 32'h1);

    // Read while empty must not move anything.
    cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    check("rx_count_empty_read", {27'h0, rx_count}, 32'h0);

    // RX overflow: 16 accepted, 17th dropped, sticky until cleared.
    for (int i = 0; i < DEPTH; i++) send_rx(8'h40 + 8'(i), 1'b1);
    check("rx_count_16", {27'h0, rx_count}, 32'd16);
    check("rx_no_overflow_yet", {31'h0, rx_overflow}, 32'h0);
    send_rx(8'hEE, 1'b0);
    check("rx_overflow_set", {31'h0, rx_overflow}, 32'h1);
    check("rx_count_still_16", {27'h0, rx_count}, 32'd16);
    tick();
    check("rx_overflow_sticky", {31'h0, rx_overflow}, 32'h1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("rx_overflow_cleared", {31'h0, rx_overflow}, 32'h0);
    cpu_rd_en = 1'b1;
    for (int k = 0; k < 40 && !rx_empty; k++) tick();
    cpu_rd_en = 1'b0;
    check("rx_readout_done", {31'h0, rx_empty}, 32'h1);
    check("rx_sb_drained", rx_q.size(), 0);

    // Reset while TX holds 5 words, RX holds one, and the link is asking for data.
    for (int i = 0; i < 5; i++) push_tx(8'h60 + 8'(i));
    send_rx(8'h77, 1'b1);
    check("pre_reset_tx_count", {27'h0, tx_count}, 32'd5);
    check("pre_reset_rx_empty", {31'h0, rx_empty}, 32'h0);
    link_out_ready = 1'b1;
    reset_reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    tick();
    reset_reset = 1'b0;
    link_out_ready = 1'b0;
    check("midreset_tx_count", {27'h0, tx_count}, 32'd0);
    check("midreset_valid", {31'h0, link_out_valid}, 32'h0);
    check("midreset_rx_empty", {31'h0, rx_empty}, 32'h1);

    // Checksum: 0xF0 + 0x20 wraps to 0x10 when enabled, otherwise tied to zero.
    csum_clr = 1'b1;
    tick();
    csum_clr = 1'b0;
    push_tx(8'hF0);
    push_tx(8'h20);
    link_out_ready = 1'b1;
    for (int k = 0; k < 10 && link_out_valid; k++) tick();
    link_out_ready = 1'b0;
`ifdef STREAM_CHECKSUM_EN
    check("tx_csum_wrap", {24'h0, tx_csum}, 32'h10);
    csum_clr = 1'b1;
    tick();
    csum_clr = 1'b0;
    check("tx_csum_cleared", {24'h0, tx_csum}, 32'h0);
`else
    check("tx_csum_tied", {24'h0, tx_csum}, 32'h0);
    check("rx_csum_tied", {24'h0, rx_csum}, 32'h0);
`endif
    check("tx_sb_drained_3", tx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
